// File: rtl/tpram_sync_fifo.sv
// Single-clock FIFO on a two-port RAM with a first-word-fall-through output register.
// Capacity is DEPTH words in RAM plus one in the output register.
module tpram_sync_fifo #(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned DEPTH         = 1024,
    parameter              RAM_STYLE_VAL = "block",
    parameter int unsigned AFULL_THRESH  = DEPTH - 1,
    parameter int unsigned AEMPTY_THRESH = 1
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic                          FLUSH,
    input  logic                          WR_VALID,
    output logic                          WR_READY,
    input  logic [DATA_WIDTH-1:0]         WR_DATA,
    output logic                          RD_VALID,
    input  logic                          RD_READY,
    output logic [DATA_WIDTH-1:0]         RD_DATA,
    output logic [$clog2(DEPTH+2)-1:0]    COUNT,
    output logic                          ALMOST_FULL,
    output logic                          ALMOST_EMPTY
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 2);
    localparam logic [AW:0] RAM_FULL = (AW+1)'(DEPTH);

    (* ram_style = RAM_STYLE_VAL *) logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [AW-1:0]         wptr;
    logic [AW-1:0]         rptr;
    logic [AW:0]           ram_cnt;
    logic [CW-1:0]         count;
    logic                  rd_valid;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  wr_ready;
    logic                  wr_en;
    logic                  rd_issue;
    logic                  pop;

    always_comb begin
        wr_ready = (ram_cnt != RAM_FULL) && !FLUSH && !RST;
        wr_en    = WR_VALID && wr_ready;
        pop      = rd_valid && RD_READY;
        rd_issue = (ram_cnt != '0) && (!rd_valid || RD_READY) && !FLUSH && !RST;
    end

    // Storage array is never reset so it stays a plain RAM.
    always_ff @(posedge CLK) begin
        if (wr_en)
            mem[wptr] <= WR_DATA;
    end

    always_ff @(posedge CLK) begin
        if (RST || FLUSH) begin
            wptr     <= '0;
            rptr     <= '0;
            ram_cnt  <= '0;
            count    <= '0;
            rd_valid <= 1'b0;
            if (RST)
                rd_data <= '0;
        end else begin
            if (wr_en)
                wptr <= wptr + 1'b1;
            if (rd_issue) begin
                rptr     <= rptr + 1'b1;
                rd_data  <= mem[rptr];
                rd_valid <= 1'b1;
            end else if (pop) begin
                rd_valid <= 1'b0;
            end
            case ({wr_en, rd_issue})
                2'b10:   ram_cnt <= ram_cnt + 1'b1;
                2'b01:   ram_cnt <= ram_cnt - 1'b1;
                default: ram_cnt <= ram_cnt;
            endcase
            count <= count + CW'(wr_en) - CW'(pop);
        end
    end

    assign WR_READY     = wr_ready;
    assign RD_VALID     = rd_valid;
    assign RD_DATA      = rd_data;
    assign COUNT        = count;
    assign ALMOST_FULL  = (32'(count) >= AFULL_THRESH);
    assign ALMOST_EMPTY = (32'(count) <= AEMPTY_THRESH);

endmodule

// File: tb/tb_tpram_sync_fifo.sv
// Scoreboard bench for tpram_sync_fifo at DEPTH=4, DATA_WIDTH=8.
module tb_tpram_sync_fifo;

    localparam int DW   = 8;
    localparam int DEP  = 4;
    localparam int CAP  = DEP + 1;
    localparam int AF_T = 4;
    localparam int AE_T = 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          flush = 1'b0;
    logic          wr_valid = 1'b0;
    logic          wr_ready;
    logic [DW-1:0] wr_data = '0;
    logic          rd_valid;
    logic          rd_ready = 1'b0;
    logic [DW-1:0] rd_data;
    logic [2:0]    count;
    logic          almost_full;
    logic          almost_empty;

    tpram_sync_fifo #(
        .DATA_WIDTH   (DW),
        .DEPTH        (DEP),
        .AFULL_THRESH (AF_T),
        .AEMPTY_THRESH(AE_T)
    ) dut (
        .CLK         (clk),
        .RST         (rst),
        .FLUSH       (flush),
        .WR_VALID    (wr_valid),
        .WR_READY    (wr_ready),
        .WR_DATA     (wr_data),
        .RD_VALID    (rd_valid),
        .RD_READY    (rd_ready),
        .RD_DATA     (rd_data),
        .COUNT       (count),
        .ALMOST_FULL (almost_full),
        .ALMOST_EMPTY(almost_empty)
    );

    always #5 clk = ~clk;

    int            n_checks = 0;
    int            n_fail   = 0;
    int            model_count = 0;
    logic [DW-1:0] sb [$];
    logic          stall_prev = 1'b0;
    logic [DW-1:0] prev_data = '0;
    logic          last_acc = 1'b0;
    int            n_pops = 0;

    // One clock step: inputs are already driven; checks run 2 time units after the edge.
    task automatic cycle();
        logic          acc;
        logic          popd;
        logic          exp_ready;
        logic [DW-1:0] exp_data;
        #1;
        acc       = wr_valid && wr_ready;
        popd      = rd_valid && rd_ready;
        exp_ready = !rst && !flush && (model_count < CAP);
        n_checks++;
        if (wr_ready !== exp_ready) begin
            n_fail++;
            $display("FAIL wr_ready: got %b expected %b (count model %0d)", wr_ready, exp_ready, model_count);
        end
        n_checks++;
        if (int'(count) !== model_count) begin
            n_fail++;
            $display("FAIL count: got %0d expected %0d", count, model_count);
        end
        n_checks++;
        if (almost_full !== (model_count >= AF_T) || almost_empty !== (model_count <= AE_T)) begin
            n_fail++;
            $display("FAIL flags: got af=%b ae=%b expected af=%b ae=%b", almost_full, almost_empty,
                     model_count >= AF_T, model_count <= AE_T);
        end
        if (stall_prev) begin
            n_checks++;
            if (rd_valid !== 1'b1 || rd_data !== prev_data) begin
                n_fail++;
                $display("FAIL stall_hold: got v=%b d=%h expected v=1 d=%h", rd_valid, rd_data, prev_data);
            end
        end
        if (popd && !flush && !rst) begin
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL pop_underflow: got d=%h expected no valid word", rd_data);
            end else begin
                exp_data = sb.pop_front();
                n_pops++;
                if (rd_data !== exp_data) begin
                    n_fail++;
                    $display("FAIL rd_data: got %h expected %h", rd_data, exp_data);
                end
            end
        end
        if (acc)
            sb.push_back(wr_data);
        last_acc   = acc;
        stall_prev = rd_valid && !rd_ready && !rst && !flush;
        prev_data  = rd_data;
        if (rst || flush) begin
            model_count = 0;
            sb.delete();
        end else begin
            model_count = model_count + int'(acc) - int'(popd);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        wr_valid = 1'b0;
        rd_ready = 1'b1;
        for (int i = 0; i < 20 && (sb.size() != 0 || rd_valid); i++)
            cycle();
        rd_ready = 1'b0;
        n_checks++;
        if (sb.size() != 0 || rd_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL drain_timeout: got %0d words left valid=%b expected 0 left valid=0", sb.size(), rd_valid);
        end
    endtask

    task automatic fill_full();
        rd_ready = 1'b0;
        for (int i = 1; i <= CAP; i++) begin
            wr_data  = DW'(i);
            wr_valid = 1'b1;
            cycle();
            n_checks++;
            if (!last_acc) begin
                n_fail++;
                $display("FAIL fill_accept: got not accepted expected accepted (word %0d)", i);
            end
        end
        wr_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        n_checks++;
        if (wr_ready !== 1'b1 || rd_valid !== 1'b0 || rd_data !== '0 || count !== '0 ||
            almost_full !== 1'b0 || almost_empty !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_state: got rdy=%b v=%b d=%h cnt=%0d af=%b ae=%b expected 1 0 00 0 0 1",
                     wr_ready, rd_valid, rd_data, count, almost_full, almost_empty);
        end
        model_count = 0;
        sb.delete();
        stall_prev = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_latency();
        rd_ready = 1'b0;
        wr_data  = 8'hA1;
        wr_valid = 1'b1;
        cycle();
        wr_valid = 1'b0;
        n_checks++;
        if (rd_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL latency_early: got rd_valid=%b expected 0 one edge after accept", rd_valid);
        end
        cycle();
        n_checks++;
        if (rd_valid !== 1'b1 || rd_data !== 8'hA1 || count !== 3'd1 || almost_empty !== 1'b1) begin
            n_fail++;
            $display("FAIL latency: got v=%b d=%h cnt=%0d ae=%b expected v=1 d=a1 cnt=1 ae=1",
                     rd_valid, rd_data, count, almost_empty);
        end
        drain();
    endtask

    task automatic test_fill_drain();
        fill_full();
        n_checks++;
        if (wr_ready !== 1'b0 || count !== 3'd5 || almost_full !== 1'b1) begin
            n_fail++;
            $display("FAIL full_state: got rdy=%b cnt=%0d af=%b expected rdy=0 cnt=5 af=1",
                     wr_ready, count, almost_full);
        end
        drain();
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] pat = 8'h40;
        int            pops_before = n_pops;
        rd_ready = 1'b1;
        wr_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            wr_data = pat;
            cycle();
            if (last_acc)
                pat = pat + 1'b1;
        end
        wr_valid = 1'b0;
        n_checks++;
        if (count !== 3'd1 && count !== 3'd2) begin
            n_fail++;
            $display("FAIL stream_count: got %0d expected 1 or 2", count);
        end
        n_checks++;
        if (n_pops - pops_before != 18) begin
            n_fail++;
            $display("FAIL stream_rate: got %0d pops expected 18", n_pops - pops_before);
        end
        drain();
    endtask

    task automatic test_full_pop_write();
        fill_full();
        rd_ready = 1'b1;
        wr_valid = 1'b1;
        wr_data  = 8'h55;
        cycle();
        n_checks++;
        if (last_acc !== 1'b0 || count !== 3'd4) begin
            n_fail++;
            $display("FAIL full_pop_same: got acc=%b cnt=%0d expected acc=0 cnt=4", last_acc, count);
        end
        rd_ready = 1'b0;
        cycle();
        wr_valid = 1'b0;
        n_checks++;
        if (last_acc !== 1'b1 || count !== 3'd5) begin
            n_fail++;
            $display("FAIL full_pop_next: got acc=%b cnt=%0d expected acc=1 cnt=5", last_acc, count);
        end
        drain();
    endtask

    task automatic test_flush();
        rd_ready = 1'b0;
        wr_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wr_data = DW'(8'h30 + i);
            cycle();
        end
        flush   = 1'b1;
        wr_data = 8'hEE;
        cycle();
        flush    = 1'b0;
        wr_valid = 1'b0;
        n_checks++;
        if (count !== 3'd0 || rd_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_state: got cnt=%0d v=%b expected cnt=0 v=0", count, rd_valid);
        end
        wr_data  = 8'h7E;
        wr_valid = 1'b1;
        cycle();
        wr_valid = 1'b0;
        cycle();
        n_checks++;
        if (rd_valid !== 1'b1 || rd_data !== 8'h7E || count !== 3'd1) begin
            n_fail++;
            $display("FAIL flush_refill: got v=%b d=%h cnt=%0d expected v=1 d=7e cnt=1", rd_valid, rd_data, count);
        end
        drain();
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] pat = 8'hC0;
        int            sent = 0;
        for (int i = 0; i < 40 && sent < 16; i++) begin
            wr_valid = 1'b1;
            wr_data  = pat;
            rd_ready = i[0];
            cycle();
            if (last_acc) begin
                pat = pat + 1'b1;
                sent++;
            end
        end
        n_checks++;
        if (sent != 16) begin
            n_fail++;
            $display("FAIL bp_sent: got %0d words accepted expected 16", sent);
        end
        drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_latency();
        test_fill_drain();
        test_back_to_back();
        test_full_pop_write();
        test_flush();
        test_backpressure();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
